logistic_synth: RTL and testbench

Parametrised successor to the logistic-map sound generator. It iterates the logistic map x' = r·x·(1−x) in fixed point on a shared sequential datapath and distributes successive iterates round-robin as frequencies to N_OSC square-wave phase oscillators. The oscillators are mixed and rendered as a 1-bit first-order sigma-delta stream on `snd`. Beyond its predecessor it adds an enable, a runtime r-sweep mode (hold / wrap / ping-pong) with runtime bounds, per-voice muting and a parallel mix level output.

---
 rtl/logistic_synth.sv | 177 +++++++++++++++++
 tb/tb_logistic_synth.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/logistic_synth.sv
// Logistic-map sound generator: a shared sequential multiplier iterates x' = r*x*(1-x),
// feeds the iterates round-robin to square-wave oscillators and renders the mix as sigma-delta.
module logistic_synth #(
    parameter int unsigned N_OSC      = 8,
    parameter int unsigned ITER_LEN   = 382,
    parameter int unsigned R_INC      = 1,
    parameter int unsigned FRAC       = 16,
    parameter int unsigned PHASE_BITS = 16,
    parameter int unsigned FREQ_RES   = 0,
    parameter int unsigned X_SEED     = 2 ** (FRAC - 1),
    parameter int unsigned R_INIT     = 7 * 2 ** (FRAC - 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic [1:0]                   mode,
    input  logic [FRAC+1:0]              r_min,
    input  logic [FRAC+1:0]              r_max,
    input  logic [N_OSC-1:0]             voice_mask,
    output logic                         snd,
    output logic [$clog2(N_OSC+1)-1:0]   level,
    output logic [FRAC+1:0]              r_out,
    output logic                         iter_strobe
);
    localparam int unsigned RW  = FRAC + 2;
    localparam int unsigned RW1 = RW + 1;
    localparam int unsigned F1  = FRAC + 1;
    localparam int unsigned P1W = 2 * FRAC + 1;
    localparam int unsigned P2W = RW + FRAC;
    localparam int unsigned LW  = $clog2(N_OSC + 1);
    localparam int unsigned SW  = LW + 1;
    localparam int unsigned IW  = $clog2(N_OSC);
    localparam int unsigned CW  = $clog2(ITER_LEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL1, S_MUL2, S_UPDATE} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          idx_q;
    logic [FRAC-1:0]        x_q, t_q, xn_q;
    logic [FRAC-1:0]        t_d, xn_d, x_d;
    logic [RW-1:0]          r_q, r_d;
    logic                   dir_up_q, dir_up_d;
    logic                   strobe_q;
    logic [F1-1:0]          one_minus_x;
    logic [P1W-1:0]         prod1;
    logic [P2W-1:0]         prod2;
    logic [RW1-1:0]         r_sum, r_lo;
    logic [FRAC-1:0]        freq_q  [N_OSC];
    logic [PHASE_BITS-1:0]  phase_q [N_OSC];
    logic [LW-1:0]          level_q, level_d, acc_q, acc_d;
    logic [SW-1:0]          sd_sum;
    logic                   snd_q, snd_d;

    // Map arithmetic; both products are truncated back to Q0.FRAC.
    always_comb begin
        one_minus_x = F1'(2 ** FRAC) - F1'(x_q);
        prod1       = P1W'(x_q) * P1W'(one_minus_x);
        t_d         = FRAC'(prod1 >> FRAC);
        prod2       = P2W'(r_q) * P2W'(t_q);
        xn_d        = FRAC'(prod2 >> FRAC);
        x_d         = (xn_q == '0) ? FRAC'(X_SEED) : xn_q;
    end

    // r sweep, applied only on the last voice of a round; inverted bounds freeze r.
    always_comb begin
        r_d      = r_q;
        dir_up_d = dir_up_q;
        r_sum    = RW1'(r_q) + RW1'(R_INC);
        r_lo     = RW1'(r_min) + RW1'(R_INC);
        if (idx_q == IW'(N_OSC - 1) && r_min <= r_max) begin
            case (mode)
                2'b01: r_d = (r_sum > RW1'(r_max)) ? r_min : RW'(r_sum);
                2'b10: begin
                    if (dir_up_q) begin
                        if (r_sum >= RW1'(r_max)) begin
                            r_d      = r_max;
                            dir_up_d = 1'b0;
                        end else begin
                            r_d = RW'(r_sum);
                        end
                    end else if (RW1'(r_q) <= r_lo) begin
                        r_d      = r_min;
                        dir_up_d = 1'b1;
                    end else begin
                        r_d = r_q - RW'(R_INC);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            x_q      <= FRAC'(X_SEED);
            t_q      <= '0;
            xn_q     <= '0;
            r_q      <= RW'(R_INIT);
            dir_up_q <= 1'b1;
            strobe_q <= 1'b0;
            for (int i = 0; i < N_OSC; i++) freq_q[i] <= '0;
        end else begin
            strobe_q <= 1'b0;
            if (ena) begin
                cnt_q <= (cnt_q == CW'(ITER_LEN - 1)) ? '0 : cnt_q + CW'(1);
                case (state_q)
                    S_IDLE:   if (cnt_q == CW'(ITER_LEN - 1)) state_q <= S_MUL1;
                    S_MUL1: begin
                        t_q     <= t_d;
                        state_q <= S_MUL2;
                    end
                    S_MUL2: begin
                        xn_q    <= xn_d;
                        state_q <= S_UPDATE;
                    end
                    S_UPDATE: begin
                        x_q           <= x_d;
                        freq_q[idx_q] <= x_d;
                        idx_q         <= (idx_q == IW'(N_OSC - 1)) ? '0 : idx_q + IW'(1);
                        r_q           <= r_d;
                        dir_up_q      <= dir_up_d;
                        strobe_q      <= 1'b1;
                        state_q       <= S_IDLE;
                    end
                    default:  state_q <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OSC; i++) phase_q[i] <= '0;
        end else if (ena) begin
            for (int i = 0; i < N_OSC; i++)
                phase_q[i] <= phase_q[i] + PHASE_BITS'(freq_q[i] >> FREQ_RES);
        end
    end

    // Mix level and first-order sigma-delta modulator.
    always_comb begin
        level_d = '0;
        for (int i = 0; i < N_OSC; i++)
            level_d = level_d + LW'(phase_q[i][PHASE_BITS-1] & voice_mask[i]);
        sd_sum = SW'(acc_q) + SW'(level_q);
        if (sd_sum >= SW'(N_OSC)) begin
            snd_d = 1'b1;
            acc_d = LW'(sd_sum - SW'(N_OSC));
        end else begin
            snd_d = 1'b0;
            acc_d = LW'(sd_sum);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            acc_q   <= '0;
            snd_q   <= 1'b0;
        end else if (ena) begin
            level_q <= level_d;
            acc_q   <= acc_d;
            snd_q   <= snd_d;
        end else begin
            snd_q <= 1'b0;
        end
    end

    assign snd         = snd_q;
    assign level       = level_q;
    assign r_out       = r_q;
    assign iter_strobe = strobe_q;
endmodule

// File: tb/tb_logistic_synth.sv
// Bench for logistic_synth: cycle model of the map, sweep, oscillators and mix,
// plus a small fast instance exercising the ping-pong sweep.
module tb_logistic_synth;
    localparam int FR    = 16;
    localparam int IL    = 382;
    localparam int NO    = 8;
    localparam int SEED  = 32768;
    localparam int RINIT = 229376;

    logic        clk, rst_n, ena;
    logic [1:0]  mode;
    logic [17:0] r_min, r_max, r_out;
    logic [7:0]  voice_mask;
    logic        snd, iter_strobe;
    logic [3:0]  level;

    logic        ena2;
    logic [1:0]  mode2;
    logic [17:0] r_min2, r_max2, r_out2;
    logic [3:0]  voice_mask2;
    logic        snd2, stb2;
    logic [2:0]  level2;

    logistic_synth dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .r_min(r_min), .r_max(r_max),
        .voice_mask(voice_mask), .snd(snd), .level(level), .r_out(r_out), .iter_strobe(iter_strobe)
    );

    logistic_synth #(.N_OSC(4), .ITER_LEN(16), .R_INIT(100)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena2), .mode(mode2), .r_min(r_min2), .r_max(r_max2),
        .voice_mask(voice_mask2), .snd(snd2), .level(level2), .r_out(r_out2), .iter_strobe(stb2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert, n_fail, cyc, first_stb, s2, last2;
    int seq2 [6] = '{100, 101, 102, 101, 100, 101};

    // Reference state
    longint m_x, m_r;
    int     m_dir_up, m_idx, m_cnt, m_pend, m_lvl, m_acc;
    int     m_freq [NO];
    int     m_ph   [NO];
    logic   m_snd, m_stb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint next_x(input longint x, input longint r);
        longint t, xn;
        t  = (x * ((64'd1 << FR) - x)) >> FR;
        xn = (r * t) >> FR;
        if (xn == 0) xn = SEED;
        return xn;
    endfunction

    task automatic r_round();
        longint lo, hi;
        lo = longint'(r_min);
        hi = longint'(r_max);
        if (lo > hi) return;
        if (mode == 2'b01) begin
            m_r = (m_r + 1 > hi) ? lo : m_r + 1;
        end else if (mode == 2'b10) begin
            if (m_dir_up != 0) begin
                if (m_r + 1 >= hi) begin m_r = hi; m_dir_up = 0; end
                else m_r = m_r + 1;
            end else begin
                if (m_r <= lo + 1) begin m_r = lo; m_dir_up = 1; end
                else m_r = m_r - 1;
            end
        end
    endtask

    // One clock: advance the model with the values the DUT sampled, then compare.
    task automatic step();
        int nl, s;
        @(posedge clk);
        if (ena) begin
            nl = 0;
            for (int i = 0; i < NO; i++)
                if (((m_ph[i] >> 15) & 1) != 0 && voice_mask[i]) nl++;
            s     = m_acc + m_lvl;
            m_snd = (s >= NO);
            m_acc = (s >= NO) ? s - NO : s;
            m_lvl = nl;
            for (int i = 0; i < NO; i++) m_ph[i] = (m_ph[i] + m_freq[i]) % 65536;
            m_stb = 1'b0;
            if (m_pend == 1) begin
                m_x = next_x(m_x, m_r);
                m_freq[m_idx] = int'(m_x);
                if (m_idx == NO - 1) r_round();
                m_idx = (m_idx + 1) % NO;
                m_stb = 1'b1;
            end
            if (m_pend > 0) m_pend--;
            if (m_cnt == IL - 1) m_pend = 3;
            m_cnt = (m_cnt + 1) % IL;
        end else begin
            m_snd = 1'b0;
            m_stb = 1'b0;
        end
        cyc++;
        #1;
        chk("snd", 64'(snd), 64'(m_snd));
        chk("level", 64'(level), 64'(m_lvl));
        chk("iter_strobe", 64'(iter_strobe), 64'(m_stb));
        chk("r_out", 64'(r_out), 64'(m_r));
        if (m_stb) chk("x_commit", 64'(dut.x_q), 64'(m_x));
        if (iter_strobe && first_stb == 0) first_stb = cyc;
        if (stb2) begin
            s2++;
            if (s2 == 1) chk("p2_first_strobe", 64'(cyc), 64'd19);
            else chk("p2_period", 64'(cyc - last2), 64'd16);
            last2 = cyc;
            if (s2 % 4 == 0 && s2 / 4 <= 5) chk("pingpong_r", 64'(r_out2), 64'(seq2[s2 / 4]));
        end
    endtask

    initial begin
        int t0, got, ones, lv_prev;
        longint sum_l, diff, r_saved;
        n_assert = 0; n_fail = 0; cyc = 0; first_stb = 0; s2 = 0; last2 = 0;
        rst_n = 1'b0; ena = 1'b0; mode = 2'b00; r_min = '0; r_max = '0; voice_mask = 8'hFF;
        ena2 = 1'b1; mode2 = 2'b10; r_min2 = 18'd100; r_max2 = 18'd102; voice_mask2 = 4'hF;
        m_x = SEED; m_r = RINIT; m_dir_up = 1; m_idx = 0; m_cnt = 0; m_pend = 0;
        m_lvl = 0; m_acc = 0; m_snd = 1'b0; m_stb = 1'b0;
        for (int i = 0; i < NO; i++) begin m_freq[i] = 0; m_ph[i] = 0; end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_snd", 64'(snd), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_strobe", 64'(iter_strobe), 64'd0);
        chk("rst_r_out", 64'(r_out), 64'(RINIT));
        chk("rst_x", 64'(dut.x_q), 64'(SEED));
        chk("rst_r_out2", 64'(r_out2), 64'd100);
        chk("rst_level2", 64'(level2), 64'd0);
        chk("rst_snd2", 64'(snd2), 64'd0);

        @(negedge clk);
        rst_n = 1'b1; ena = 1'b1;

        // Defaults: first iterates and hold mode
        repeat (800) step();
        chk("first_strobe_clock", 64'(first_stb), 64'd385);
        chk("freq0", 64'(dut.freq_q[0]), 64'd57344);
        chk("freq1", 64'(dut.freq_q[1]), 64'd25088);
        chk("p2_rounds_seen", 64'(s2 >= 20), 64'd1);
        repeat (2 * NO * IL) step();
        chk("hold_r", 64'(r_out), 64'(RINIT));

        // All voices muted
        voice_mask = 8'h00;
        repeat (400) step();
        chk("mute_level", 64'(level), 64'd0);
        chk("mute_snd", 64'(snd), 64'd0);
        voice_mask = 8'hFF;

        // Freeze in the middle of the second multiply
        for (int i = 0; i < 2 * IL; i++) begin
            step();
            if (m_pend == 2) break;
        end
        ena = 1'b0;
        t0 = cyc;
        repeat (1000) step();
        ena = 1'b1;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (iter_strobe) begin got = cyc - t0; break; end
        end
        chk("resume_strobe_delay", 64'(got), 64'd1002);

        // Sweep with wrap between two adjacent r values
        mode = 2'b01; r_min = 18'd229376; r_max = 18'd229377;
        repeat (3 * NO * IL) step();

        // Sigma-delta density against observed level
        mode = 2'b00;
        ones = 0; sum_l = 0; lv_prev = int'(level);
        repeat (40000) begin
            step();
            ones += int'(snd);
            sum_l += lv_prev;
            lv_prev = int'(level);
        end
        diff = longint'(ones) * NO - sum_l;
        chk("density", 64'(diff <= NO && diff >= -NO), 64'd1);

        // Inverted bounds freeze r
        mode = 2'b01; r_min = 18'd5; r_max = 18'd4;
        r_saved = m_r;
        repeat (NO * IL + 10) step();
        chk("inverted_bounds_hold", 64'(r_out), 64'(r_saved));

        // r collapses to 0; every iterate escapes to the seed
        r_min = 18'd0; r_max = 18'd0;
        repeat (3 * NO * IL) step();
        chk("zero_r", 64'(r_out), 64'd0);
        chk("zero_x", 64'(dut.x_q), 64'(SEED));
        for (int i = 0; i < NO; i++) chk("zero_freq", 64'(dut.freq_q[i]), 64'(SEED));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
